pmod_dac_axil_ctrl: RTL and testbench
=====================================

Name: pmod_dac_axil_ctrl

Overview:
- AXI4-Lite slave driving a multi-channel SPI DAC of the AD5628/AD5668 family on a PMOD port.
- Generalised successor of the single-mode PMOD DA4 controller: parametrised channel count, DAC resolution and SCLK rate.
- Adds batch mode (stage many channels, one simultaneous update), per-channel dirty tracking, status readback and an optional reference-enable frame issued at reset.
- Sits between the PS AXI interconnect and the PMOD pins; PYNQ drivers access it through the register map below.

Parameters:
- NUM_CH, 8, number of DAC channels (1..8); channel address = index.
- DAC_BITS, 12, DAC resolution (12 or 16); data is right-aligned in the AXI word.
- SCLK_DIV, 4, ACLK cycles per SCLK half-period (>=1).
- SYNC_GAP, 4, ACLK cycles SYNC_N stays high between frames (>=1).
- INIT_REF, 1, when 1, send the internal-reference-enable frame once after reset.
- C_S_AXI_ADDR_WIDTH, 6, AXI address width.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave channels, 32-bit data, C_S_AXI_ADDR_WIDTH address, WSTRB ignored; PROT accepted and unused.
- DAC_SYNC_N  out  1  frame select, active low.
- DAC_SCLK  out  1  serial clock.
- DAC_DIN  out  1  serial data, MSB first.
- BUSY  out  1  high while the engine is outside IDLE or any dirty bit is set.

Behaviour:
- Reset values: DAC_SYNC_N=1, DAC_SCLK=0, DAC_DIN=0, BUSY=0. All AXI READY/VALID outputs 0. CH_DATA=0, CTRL=0, dirty mask=0.
- Reset mid-frame aborts immediately; the partial frame is discarded by the DAC because SYNC_N rises early.
- Register map (byte offset):
  - 0x00+4n, CH_DATA[n], RW, bits[DAC_BITS-1:0], n<NUM_CH.
  - 0x20, CTRL, RW: bit0 MODE (0 immediate, 1 batch); bit1 GO (write-1 pulse, reads 0).
  - 0x24, STATUS, RO: bit0 busy; bits[8+NUM_CH-1:8] dirty mask.
  - Any other offset: reads 0, writes ignored, response OKAY.
- AXI write: AWREADY and WREADY both assert for one cycle once AWVALID and WVALID are both high. BVALID follows the next cycle and holds until BREADY. No new write is accepted while BVALID=1.
- AXI read: ARREADY asserts for one cycle; RVALID follows the next cycle with data and holds until RREADY. All responses OKAY.
- Dirty bit n is set by any write to CH_DATA[n]. It is cleared when the engine latches channel n into the shift register. If both happen in the same cycle, set wins.
- Frame format (32 bits): [31:28]=0, [27:24]=cmd, [23:20]=channel, [19:20-DAC_BITS]=data, remaining low bits 0.
- Engine FSM: INIT → IDLE → LOAD → SHIFT → GAP → IDLE.
  - INIT (only if INIT_REF=1): sends cmd 0x8 with word bit0=1, then goes to GAP.
  - IDLE, immediate mode: if any dirty bit is set, LOAD the lowest dirty index with cmd 0x3 (write and update n).
  - IDLE, batch mode: dirty bits are held. A GO pulse with a nonzero mask snapshots the mask. Channels are sent in ascending order with cmd 0x0; the last one uses cmd 0x2 (write n, update all). GO with an empty mask, or GO while a batch is running, is ignored.
  - LOAD: one cycle; latches the frame and the channel data.
  - SHIFT: SYNC_N=0 for 32 SCLK periods. DIN changes SCLK_DIV cycles before each SCLK falling edge, so it is stable at the falling edge where the DAC samples. SCLK returns low; SYNC_N rises SCLK_DIV cycles after the last falling edge.
  - GAP: holds SYNC_N high for SYNC_GAP cycles.
- Frame duration = 1 (LOAD) + 64·SCLK_DIV + SCLK_DIV + SYNC_GAP ACLK cycles.
- Writes during SHIFT update CH_DATA and dirty bits only. The in-flight frame uses its latched data.
- Switching MODE from 1 to 0 with dirty bits pending drains them in immediate mode. Switching from 0 to 1 holds any dirty bits not yet latched.
- Writes to CH_DATA are masked to DAC_BITS; upper read bits are 0.

Test Plan:
- Reset release with INIT_REF=1, SCLK_DIV=4 → one frame 0x08000001 on DIN, then SYNC_N high and BUSY=0; frame timing per the formula.
- Immediate mode: write CH_DATA[2]=0xABC (12-bit) → frame 0x032ABC00. Reading 0x08 returns 0x00000ABC; STATUS dirty mask returns to 0.
- Batch mode: write ch5=0x123, ch1=0xFFF, then GO → frames 0x001FFF00, then 0x025123 00 (0x02512300) in that order. BUSY stays high until the final GAP ends.
- Write ch0=0x111 then ch0=0x222 during its SHIFT (immediate) → frame with 0x111, then a second frame 0x03022200.
- ARESETN low at SCLK edge 10 of a frame → SYNC_N=1 and SCLK=0 immediately; registers read 0 after release.
- Read 0x30 (unmapped) → 0 with OKAY. Write to STATUS → no effect. GO with empty mask → no frame and BUSY stays 0.

Source files
------------

// File: rtl/pmod_dac_axil_ctrl.sv
// pmod_dac_axil_ctrl
//   AXI4-Lite slave that drives a multi-channel AD5628/AD5668-style SPI DAC.
//   Channel writes mark a channel dirty. In immediate mode dirty channels are
//   sent lowest first with write-and-update. In batch mode the dirty mask is
//   snapshotted on GO and sent in ascending order, with the last frame
//   updating all outputs at once.
// Ports
//   ACLK, ARESETN        clock, asynchronous active-low reset
//   S_AXI_*              AXI4-Lite slave, 32-bit data (WSTRB/PROT unused)
//   DAC_SYNC_N/SCLK/DIN  SPI frame select, serial clock, serial data (MSB first)
//   BUSY                 engine not idle or any channel dirty
module pmod_dac_axil_ctrl #(
    parameter int NUM_CH             = 8,
    parameter int DAC_BITS           = 12,
    parameter int SCLK_DIV           = 4,
    parameter int SYNC_GAP           = 4,
    parameter int INIT_REF           = 1,
    parameter int C_S_AXI_ADDR_WIDTH = 6
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]                    S_AXI_AWPROT,
    input  logic                          S_AXI_AWVALID,
    output logic                          S_AXI_AWREADY,
    input  logic [31:0]                   S_AXI_WDATA,
    input  logic [3:0]                    S_AXI_WSTRB,
    input  logic                          S_AXI_WVALID,
    output logic                          S_AXI_WREADY,
    output logic [1:0]                    S_AXI_BRESP,
    output logic                          S_AXI_BVALID,
    input  logic                          S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]                    S_AXI_ARPROT,
    input  logic                          S_AXI_ARVALID,
    output logic                          S_AXI_ARREADY,
    output logic [31:0]                   S_AXI_RDATA,
    output logic [1:0]                    S_AXI_RRESP,
    output logic                          S_AXI_RVALID,
    input  logic                          S_AXI_RREADY,
    output logic                          DAC_SYNC_N,
    output logic                          DAC_SCLK,
    output logic                          DAC_DIN,
    output logic                          BUSY
);
    localparam int IW  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int DCW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int GCW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam int PAD = 20 - DAC_BITS;

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t                           state, state_nxt;
    logic [NUM_CH-1:0][DAC_BITS-1:0]  ch_data;
    logic [NUM_CH-1:0]                dirty, dirty_nxt, bmask, bmask_nxt, ch_wr, src, rest;
    logic                             mode;
    logic [31:0]                      sreg, rd_mux;
    logic [DAC_BITS-1:0]              ld_data;
    logic [3:0]                       ld_ch, ld_cmd, pick_ch, pick_cmd;
    logic                             ld_batch, pick_any, pick_batch;
    logic [DCW-1:0]                   div_cnt;
    logic [6:0]                       half_cnt;
    logic [GCW-1:0]                   gap_cnt;
    logic                             shift_done, gap_done;
    logic                             wr_fire, rd_fire, ctrl_wr, go_snap, batch_busy;
    logic [IW-1:0]                    widx, ridx;
    logic                             unused_ok;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_WDATA,
                         S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_BRESP = 2'b00;
    assign S_AXI_RRESP = 2'b00;
    assign widx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ridx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_fire = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign rd_fire = S_AXI_ARREADY && S_AXI_ARVALID;
    assign ctrl_wr = wr_fire && (widx == IW'(8));

    // A batch counts as running until its last frame has left GAP.
    assign batch_busy = (|bmask) || (state != S_IDLE && ld_batch);
    assign go_snap    = ctrl_wr && S_AXI_WDATA[1] && S_AXI_WDATA[0] && !batch_busy && (|dirty_nxt);

    // AXI handshakes
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
            S_AXI_WREADY  <= S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID;
            if (wr_fire)           S_AXI_BVALID <= 1'b1;
            else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
            S_AXI_ARREADY <= S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
            if (rd_fire) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        for (int n = 0; n < NUM_CH; n++)
            if (ridx == IW'(n)) rd_mux = 32'(ch_data[n]);
        if (ridx == IW'(8)) rd_mux = {31'b0, mode};
        if (ridx == IW'(9)) rd_mux = 32'({dirty, 7'b0, BUSY});
    end

    // Channel write strobes, dirty tracking (set beats clear), batch mask
    always_comb begin
        ch_wr     = '0;
        dirty_nxt = dirty;
        bmask_nxt = bmask;
        for (int n = 0; n < NUM_CH; n++) begin
            ch_wr[n] = wr_fire && (widx == IW'(n));
            if (state == S_LOAD && ld_ch == 4'(n)) begin
                dirty_nxt[n] = 1'b0;
                if (ld_batch) bmask_nxt[n] = 1'b0;
            end
            if (ch_wr[n]) dirty_nxt[n] = 1'b1;
        end
        if (go_snap) bmask_nxt = dirty_nxt;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ch_data <= '0;
            mode    <= 1'b0;
            dirty   <= '0;
            bmask   <= '0;
            BUSY    <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++)
                if (ch_wr[n]) ch_data[n] <= S_AXI_WDATA[DAC_BITS-1:0];
            if (ctrl_wr) mode <= S_AXI_WDATA[0];
            dirty <= dirty_nxt;
            bmask <= bmask_nxt;
            BUSY  <= (state_nxt != S_IDLE) || (|dirty_nxt);
        end
    end

    // Next channel: a running batch has priority; otherwise immediate mode
    // drains dirty bits. rest clears the lowest set bit to spot the last one.
    always_comb begin
        pick_ch    = '0;
        pick_batch = |bmask;
        src        = pick_batch ? bmask : (mode ? '0 : dirty);
        rest       = src & (src - 1'b1);
        pick_any   = |src;
        for (int n = NUM_CH - 1; n >= 0; n--)
            if (src[n]) pick_ch = 4'(n);
        pick_cmd   = !pick_batch ? 4'h3 : ((rest == '0) ? 4'h2 : 4'h0);
        ld_data    = '0;
        for (int n = 0; n < NUM_CH; n++)
            if (ld_ch == 4'(n)) ld_data = ch_data[n];
    end

    assign shift_done = (state == S_SHIFT) && (half_cnt == 7'd64) && (div_cnt == DCW'(SCLK_DIV - 1));
    assign gap_done   = (state == S_GAP) && (gap_cnt == GCW'(SYNC_GAP - 1));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= (INIT_REF != 0) ? S_INIT : S_IDLE;
        else          state <= state_nxt;
    end

    // GAP hands straight to LOAD when work is pending so back-to-back
    // frames keep the nominal frame period.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_SHIFT;
            S_IDLE:  if (pick_any) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_SHIFT;
            S_SHIFT: if (shift_done) state_nxt = S_GAP;
            S_GAP:   if (gap_done) state_nxt = pick_any ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Serial engine. Each bit spans two half-periods: SCLK low then high.
    // DIN moves on the rising edge, SCLK_DIV cycles ahead of the sampling
    // falling edge; a final low half-period precedes SYNC_N rising.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sreg       <= '0;
            DAC_DIN    <= 1'b0;
            DAC_SCLK   <= 1'b0;
            DAC_SYNC_N <= 1'b1;
            div_cnt    <= '0;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            ld_ch      <= '0;
            ld_cmd     <= '0;
            ld_batch   <= 1'b0;
        end else begin
            if (state_nxt == S_LOAD) begin
                ld_ch    <= pick_ch;
                ld_cmd   <= pick_cmd;
                ld_batch <= pick_batch;
            end
            case (state)
                S_INIT: sreg <= 32'h0800_0001;
                S_LOAD: sreg <= 32'({4'h0, ld_cmd, ld_ch, ld_data}) << PAD;
                S_SHIFT: begin
                    if (div_cnt == DCW'(SCLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 7'd1;
                        if (shift_done) begin
                            DAC_SCLK   <= 1'b0;
                            DAC_SYNC_N <= 1'b1;
                        end else begin
                            DAC_SCLK <= ~half_cnt[0];
                            if (!half_cnt[0]) begin
                                DAC_DIN <= sreg[31];
                                sreg    <= sreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                S_GAP:   gap_cnt <= gap_cnt + 1'b1;
                default: ;
            endcase
            if (state_nxt == S_SHIFT && state != S_SHIFT) begin
                DAC_SYNC_N <= 1'b0;
                div_cnt    <= '0;
                half_cnt   <= '0;
            end
            if (state_nxt == S_GAP && state != S_GAP) begin
                gap_cnt <= '0;
                DAC_DIN <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pmod_dac_axil_ctrl.sv
// Testbench for pmod_dac_axil_ctrl: a DAC-side model captures frames on
// SCLK falling edges; expected frames come from a channel/dirty model.
module tb_pmod_dac_axil_ctrl;
    localparam int NUM_CH   = 8;
    localparam int DAC_BITS = 12;
    localparam int SCLK_DIV = 4;
    localparam int SYNC_GAP = 4;
    localparam int AW       = 6;
    localparam int LOWLEN   = 65 * SCLK_DIV;
    localparam int PERIOD   = 1 + 64 * SCLK_DIV + SCLK_DIV + SYNC_GAP;

    logic          ACLK = 1'b0;
    logic          ARESETN;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [2:0]    AWPROT, ARPROT;
    logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0]   WDATA, RDATA;
    logic [3:0]    WSTRB;
    logic [1:0]    BRESP, RRESP;
    logic          SYNC_N, SCLK, DIN, BUSY;

    pmod_dac_axil_ctrl #(
        .NUM_CH(NUM_CH), .DAC_BITS(DAC_BITS), .SCLK_DIV(SCLK_DIV),
        .SYNC_GAP(SYNC_GAP), .INIT_REF(1), .C_S_AXI_ADDR_WIDTH(AW)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .DAC_SYNC_N(SYNC_N), .DAC_SCLK(SCLK), .DAC_DIN(DIN), .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge ACLK) cyc++;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    // DAC-side model: shift in DIN on each falling SCLK while SYNC_N low;
    // a frame is accepted only if exactly 32 bits arrived before SYNC_N rose.
    logic [31:0] sh;
    int nbits = 0, fall_cyc = 0, prev_fall_cyc = 0, rise_cyc = 0, aborted = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];

    always @(negedge SYNC_N) begin
        prev_fall_cyc = fall_cyc;
        fall_cyc = cyc;
        nbits = 0;
    end
    always @(negedge SCLK) if (SYNC_N === 1'b0) begin
        sh = {sh[30:0], DIN};
        nbits++;
    end
    always @(posedge SYNC_N) begin
        rise_cyc = cyc;
        if (nbits == 32) begin
            got_q.push_back(sh);
            chk("sync_low_len", rise_cyc - fall_cyc, LOWLEN);
        end else if (nbits != 0) begin
            aborted++;
        end
        nbits = 0;
    end

    // Reference register model
    int model_ch[NUM_CH];

    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d);
        int n;
        @(negedge ACLK);
        AWADDR = a; WDATA = d; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 100) begin @(negedge ACLK); n++; end
        if (n >= 100) chk("aw_handshake_timeout", 1, 0);
        @(posedge ACLK); #1;
        AWVALID = 1'b0; WVALID = 1'b0;
        @(negedge ACLK);
        n = 0;
        while (!BVALID && n < 100) begin @(negedge ACLK); n++; end
        if (n >= 100) chk("b_timeout", 1, 0);
        chk("bresp", 32'(BRESP), 0);
        @(posedge ACLK); #1;
        if (a < 6'h20) model_ch[a >> 2] = d & 32'hFFF;
    endtask

    task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d);
        int n;
        @(negedge ACLK);
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 100) begin @(negedge ACLK); n++; end
        if (n >= 100) chk("ar_timeout", 1, 0);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        @(negedge ACLK);
        n = 0;
        while (!RVALID && n < 100) begin @(negedge ACLK); n++; end
        if (n >= 100) chk("r_timeout", 1, 0);
        d = RDATA;
        if (RRESP !== 2'b00) chk("rresp", 32'(RRESP), 0);
        @(posedge ACLK); #1;
    endtask

    task automatic check_frames(input string name);
        int n, want;
        want = exp_q.size();
        n = 0;
        while (got_q.size() < want && n < 20000) begin @(posedge ACLK); n++; end
        chk({name, "_count"}, got_q.size(), want);
        repeat (SYNC_GAP + 2) @(posedge ACLK);
        while (exp_q.size() > 0 && got_q.size() > 0) chk(name, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        chk({name, "_extra"}, got_q.size(), 0);
        got_q.delete();
    endtask

    task automatic wait_sync_low();
        int n = 0;
        while (SYNC_N !== 1'b0 && n < 2000) begin @(negedge ACLK); n++; end
        if (n >= 2000) chk("sync_low_timeout", 1, 0);
    endtask

    function automatic logic [31:0] frame(input int cmd, input int ch, input int data);
        return 32'((cmd << 24) | (ch << 20) | ((data & 'hFFF) << 8));
    endfunction

    typedef struct {
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
        logic [AW-1:0] raddr;
        logic [31:0]   rexp;
    } vec_t;
    vec_t tbl[5];

    logic [31:0] rd;
    int n, mask, last, ch, d;

    initial begin
        tbl[0] = '{6'h00, 32'hFFFF_F123, 6'h00, 32'h0000_0123};
        tbl[1] = '{6'h1C, 32'h0000_0ABC, 6'h1C, 32'h0000_0ABC};
        tbl[2] = '{6'h30, 32'hDEAD_BEEF, 6'h30, 32'h0000_0000};
        tbl[3] = '{6'h24, 32'hFFFF_FFFF, 6'h24, 32'h0000_8101};
        tbl[4] = '{6'h3C, 32'h0000_0001, 6'h20, 32'h0000_0001};
        foreach (model_ch[i]) model_ch[i] = 0;

        ARESETN = 1'b0;
        AWADDR = '0; ARADDR = '0; AWPROT = '0; ARPROT = '0; WSTRB = 4'hF;
        AWVALID = 0; WVALID = 0; ARVALID = 0; WDATA = '0;
        BREADY = 1'b1; RREADY = 1'b1;
        repeat (3) @(negedge ACLK);
        chk("reset_outputs", 32'({SYNC_N, SCLK, DIN, BUSY, AWREADY, WREADY, BVALID, ARREADY, RVALID}), 32'h100);
        ARESETN = 1'b1;

        // Reference-enable frame after reset
        exp_q.push_back(32'h0800_0001);
        check_frames("init_frame");
        chk("init_idle", 32'({BUSY, SYNC_N}), 32'b01);

        // Immediate mode single write
        axi_write(6'h08, 32'h0000_0ABC);
        exp_q.push_back(32'h032A_BC00);
        check_frames("imm_ch2");
        axi_read(6'h08, rd);  chk("read_ch2", rd, 32'h0000_0ABC);
        axi_read(6'h24, rd);  chk("status_drained", rd, 0);

        // Rewrite during SHIFT: in-flight frame keeps old data
        axi_write(6'h00, 32'h111);
        wait_sync_low();
        axi_write(6'h00, 32'h222);
        exp_q.push_back(32'h0301_1100);
        exp_q.push_back(32'h0302_2200);
        check_frames("rewrite");
        chk("frame_period", fall_cyc - prev_fall_cyc, PERIOD);

        // Batch mode: ch5, ch1 held, then one GO
        axi_write(6'h20, 32'h1);
        axi_write(6'h14, 32'h123);
        axi_write(6'h04, 32'hFFF);
        repeat (10) @(negedge ACLK);
        chk("batch_held_sync", 32'(SYNC_N), 1);
        axi_read(6'h24, rd);  chk("batch_status", rd, 32'h0000_2201);
        axi_write(6'h20, 32'h3);
        n = 0;
        while (BUSY && n < 2000) begin @(negedge ACLK); n++; end
        chk("batch_frames_before_idle", got_q.size(), 2);
        chk("busy_after_last_sync", cyc - rise_cyc, SYNC_GAP);
        exp_q.push_back(32'h001F_FF00);
        exp_q.push_back(32'h0251_2300);
        check_frames("batch");
        chk("batch_period", fall_cyc - prev_fall_cyc, PERIOD);

        // Register table (still batch mode, so channel writes are held)
        for (int i = 0; i < 5; i++) begin
            axi_write(tbl[i].waddr, tbl[i].wdata);
            axi_read(tbl[i].raddr, rd);
            chk($sformatf("table_%0d", i), rd, tbl[i].rexp);
        end
        axi_write(6'h20, 32'h3);
        exp_q.push_back(32'h0001_2300);
        exp_q.push_back(32'h027A_BC00);
        check_frames("table_batch");

        // GO with empty mask
        axi_write(6'h20, 32'h3);
        repeat (30) @(negedge ACLK);
        chk("go_empty_busy", 32'(BUSY), 0);
        chk("go_empty_frames", got_q.size(), 0);

        // Held dirty bit drained by switching to immediate
        axi_write(6'h18, 32'h5A5);
        repeat (10) @(negedge ACLK);
        chk("held_busy_sync", 32'({BUSY, SYNC_N}), 32'b11);
        axi_write(6'h20, 32'h0);
        exp_q.push_back(32'h0365_A500);
        check_frames("mode_switch");

        // Random immediate writes
        for (int i = 0; i < 6; i++) begin
            ch = $urandom_range(0, NUM_CH - 1);
            d  = $urandom;
            axi_write(6'(ch * 4), 32'(d));
            exp_q.push_back(frame(3, ch, d));
            check_frames("rand_imm");
        end

        // Random batches, some channels written twice
        axi_write(6'h20, 32'h1);
        for (int r = 0; r < 3; r++) begin
            mask = $urandom_range(1, (1 << NUM_CH) - 1);
            for (int c = 0; c < NUM_CH; c++) if (mask[c]) begin
                axi_write(6'(c * 4), $urandom);
                if ($urandom_range(0, 1) == 1) axi_write(6'(c * 4), $urandom);
            end
            last = 0;
            for (int c = 0; c < NUM_CH; c++) if (mask[c]) last = c;
            for (int c = 0; c < NUM_CH; c++)
                if (mask[c]) exp_q.push_back(frame((c == last) ? 2 : 0, c, model_ch[c]));
            axi_write(6'h20, 32'h3);
            check_frames("rand_batch");
        end
        for (int c = 0; c < NUM_CH; c++) begin
            axi_read(6'(c * 4), rd);
            chk($sformatf("readback_ch%0d", c), rd, 32'(model_ch[c]));
        end

        // Reset mid-frame
        axi_write(6'h20, 32'h0);
        axi_write(6'h0C, 32'h777);
        wait_sync_low();
        n = 0;
        while (nbits < 5 && n < 2000) begin @(posedge ACLK); n++; end
        #1 ARESETN = 1'b0;
        #1 chk("abort_pins", 32'({SYNC_N, SCLK}), 32'b10);
        foreach (model_ch[i]) model_ch[i] = 0;
        repeat (3) @(negedge ACLK);
        chk("aborted_frames", aborted, 1);
        got_q.delete();
        ARESETN = 1'b1;
        exp_q.push_back(32'h0800_0001);
        check_frames("reinit");
        axi_read(6'h0C, rd);  chk("abort_ch3", rd, 0);
        axi_read(6'h20, rd);  chk("abort_ctrl", rd, 0);
        axi_read(6'h24, rd);  chk("abort_status", rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
